// File: rtl/spandex_pkg.sv
// Shared spandex definitions: the INVALID state encoding, the default tracker depth and the L2 request-entry layout.
package spandex_pkg;

    localparam int unsigned L2_REQS_N_ENTRIES = 4;
    localparam int unsigned ST_INVALID        = 0;

    localparam int unsigned REQS_TAG_W = 20;
    localparam int unsigned REQS_SET_W = 8;
    localparam int unsigned REQS_ST_W  = 5;
    localparam int unsigned REQS_CNT_W = 4;
    localparam int unsigned REQS_PAY_W = 64;

    // Entry layout at the default widths, for callers that carry entries around whole.
    typedef struct packed {
        logic [REQS_ST_W-1:0]  state;
        logic [REQS_TAG_W-1:0] tag;
        logic [REQS_SET_W-1:0] set;
        logic [REQS_CNT_W-1:0] cnt;
        logic [REQS_PAY_W-1:0] payload;
    } reqs_entry_t;

endpackage

// File: rtl/l2_reqs_prio_enc.sv
// Priority encoder over a request vector; HIGH selects highest set index, else lowest.
// Purely combinational; returns 0 when no request bit is set.
module l2_reqs_prio_enc #(
    parameter int N    = 4,
    parameter int W    = 2,
    parameter bit HIGH = 1'b0
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx
);

    always_comb begin
        idx = '0;
        if (HIGH) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/l2_reqs_tracker.sv
// L2 outstanding-request table: alloc/free/state writes, tag+set lookup, invack counting.
// Lookup, inv_done and occupancy outputs are registered (1 cycle); alloc_ready drops when full.
module l2_reqs_tracker
    import spandex_pkg::*;
#(
    parameter int N_ENTRIES = L2_REQS_N_ENTRIES,
    parameter int TAG_W     = 20,
    parameter int SET_W     = 8,
    parameter int ST_W      = 5,
    parameter int CNT_W     = 4,
    parameter int PAY_W     = 64,
    localparam int IDX_W    = $clog2(N_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic [SET_W-1:0] alloc_set,
    input  logic [ST_W-1:0]  alloc_state,
    input  logic [PAY_W-1:0] alloc_payload,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             lookup_en,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic [SET_W-1:0] lookup_set,
    output logic             lookup_hit,
    output logic [IDX_W-1:0] lookup_idx,
    output logic             set_conflict,
    input  logic             wr_state_en,
    input  logic [IDX_W-1:0] wr_state_idx,
    input  logic [ST_W-1:0]  wr_state_data,
    input  logic             free_en,
    input  logic [IDX_W-1:0] free_idx,
    input  logic             inv_ld_en,
    input  logic [IDX_W-1:0] inv_ld_idx,
    input  logic [CNT_W-1:0] inv_ld_cnt,
    input  logic             inv_dec_en,
    input  logic [IDX_W-1:0] inv_dec_idx,
    output logic             inv_done,
    output logic [IDX_W-1:0] inv_done_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [ST_W-1:0]  rd_state,
    output logic [TAG_W-1:0] rd_tag,
    output logic [PAY_W-1:0] rd_payload,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             full,
    output logic             empty,
    output logic [IDX_W:0]   free_cnt
);

    localparam logic [ST_W-1:0] ST_INV = ST_W'(ST_INVALID);

    logic [ST_W-1:0]  state_q [N_ENTRIES];
    logic [ST_W-1:0]  state_d [N_ENTRIES];
    logic [TAG_W-1:0] tag_q   [N_ENTRIES];
    logic [TAG_W-1:0] tag_d   [N_ENTRIES];
    logic [SET_W-1:0] set_q   [N_ENTRIES];
    logic [SET_W-1:0] set_d   [N_ENTRIES];
    logic [PAY_W-1:0] pay_q   [N_ENTRIES];
    logic [PAY_W-1:0] pay_d   [N_ENTRIES];
    logic [CNT_W-1:0] cnt_q   [N_ENTRIES];
    logic [CNT_W-1:0] cnt_d   [N_ENTRIES];

    logic [N_ENTRIES-1:0] valid, tag_match, set_match, done_vec;
    logic [IDX_W-1:0]     lk_idx;
    logic                 alloc_fire;

    logic             lookup_hit_q, lookup_hit_d, set_conflict_q, set_conflict_d;
    logic [IDX_W-1:0] lookup_idx_q, lookup_idx_d, inv_done_idx_q, inv_done_idx_d;
    logic             inv_done_q, inv_done_d, full_q, full_d, empty_q, empty_d;
    logic [IDX_W:0]   free_cnt_q, free_cnt_d;

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            valid[i]     = (state_q[i] != ST_INV);
            set_match[i] = valid[i] && (set_q[i] == lookup_set);
            tag_match[i] = set_match[i] && (tag_q[i] == lookup_tag);
        end
    end

    l2_reqs_prio_enc #(.N(N_ENTRIES), .W(IDX_W), .HIGH(1'b0)) u_alloc_enc (
        .req (~valid),
        .idx (alloc_idx)
    );

    l2_reqs_prio_enc #(.N(N_ENTRIES), .W(IDX_W), .HIGH(1'b1)) u_lookup_enc (
        .req (tag_match),
        .idx (lk_idx)
    );

    assign alloc_ready = !full_q;
    assign alloc_fire  = alloc_valid && alloc_ready;

    always_comb begin
        done_vec       = '0;
        free_cnt_d     = '0;
        inv_done_idx_d = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            tag_d[i]   = tag_q[i];
            set_d[i]   = set_q[i];
            pay_d[i]   = pay_q[i];
            cnt_d[i]   = cnt_q[i];

            if (wr_state_en && wr_state_idx == IDX_W'(i)) state_d[i] = wr_state_data;
            if (free_en && free_idx == IDX_W'(i))         state_d[i] = ST_INV;
            // The alloc target is always invalid, so it never collides with a free.
            if (alloc_fire && alloc_idx == IDX_W'(i)) begin
                state_d[i] = alloc_state;
                tag_d[i]   = alloc_tag;
                set_d[i]   = alloc_set;
                pay_d[i]   = alloc_payload;
                cnt_d[i]   = '1;
            end

            if (valid[i]) begin
                if (inv_ld_en && inv_ld_idx == IDX_W'(i)) begin
                    cnt_d[i]    = inv_ld_cnt;
                    done_vec[i] = (inv_ld_cnt == '0);
                end else if (inv_dec_en && inv_dec_idx == IDX_W'(i) && cnt_q[i] != '0) begin
                    cnt_d[i]    = cnt_q[i] - 1'b1;
                    done_vec[i] = (cnt_q[i] == CNT_W'(1));
                end
            end

            if (state_d[i] == ST_INV) free_cnt_d = free_cnt_d + (IDX_W+1)'(1);
            if (done_vec[i]) inv_done_idx_d = IDX_W'(i);
        end

        inv_done_d     = |done_vec;
        full_d         = (free_cnt_d == '0);
        empty_d        = (free_cnt_d == (IDX_W+1)'(N_ENTRIES));
        lookup_hit_d   = lookup_en ? |tag_match : lookup_hit_q;
        lookup_idx_d   = lookup_en ? lk_idx     : lookup_idx_q;
        set_conflict_d = lookup_en ? |set_match : set_conflict_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                state_q[i] <= ST_INV;
                tag_q[i]   <= '0;
                set_q[i]   <= '0;
                pay_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            lookup_hit_q   <= 1'b0;
            lookup_idx_q   <= '0;
            set_conflict_q <= 1'b0;
            inv_done_q     <= 1'b0;
            inv_done_idx_q <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            free_cnt_q     <= (IDX_W+1)'(N_ENTRIES);
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                tag_q[i]   <= tag_d[i];
                set_q[i]   <= set_d[i];
                pay_q[i]   <= pay_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            lookup_hit_q   <= lookup_hit_d;
            lookup_idx_q   <= lookup_idx_d;
            set_conflict_q <= set_conflict_d;
            inv_done_q     <= inv_done_d;
            inv_done_idx_q <= inv_done_idx_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            free_cnt_q     <= free_cnt_d;
        end
    end

    // inv_done carries a single index, so two entries finishing together cannot be reported.
    always_ff @(posedge clk) begin
        if (!rst) assert ($onehot0(done_vec));
    end

    assign lookup_hit   = lookup_hit_q;
    assign lookup_idx   = lookup_idx_q;
    assign set_conflict = set_conflict_q;
    assign inv_done     = inv_done_q;
    assign inv_done_idx = inv_done_idx_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign free_cnt     = free_cnt_q;

    assign rd_state   = state_q[rd_idx];
    assign rd_tag     = tag_q[rd_idx];
    assign rd_payload = pay_q[rd_idx];
    assign rd_cnt     = cnt_q[rd_idx];

endmodule

// File: tb/tb_l2_reqs_tracker.sv
// Directed bench for l2_reqs_tracker: stimulus pushes expected alloc/lookup/done results,
// a negedge monitor pops and compares them when the DUT presents them.
module tb_l2_reqs_tracker;

    localparam int N = 4, TAG_W = 20, SET_W = 8, ST_W = 5, CNT_W = 4, PAY_W = 64, IDX_W = 2;

    logic             clk = 1'b0, rst;
    logic             alloc_valid, alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic [SET_W-1:0] alloc_set;
    logic [ST_W-1:0]  alloc_state;
    logic [PAY_W-1:0] alloc_payload;
    logic [IDX_W-1:0] alloc_idx;
    logic             lookup_en, lookup_hit, set_conflict;
    logic [TAG_W-1:0] lookup_tag;
    logic [SET_W-1:0] lookup_set;
    logic [IDX_W-1:0] lookup_idx;
    logic             wr_state_en, free_en, inv_ld_en, inv_dec_en, inv_done;
    logic [IDX_W-1:0] wr_state_idx, free_idx, inv_ld_idx, inv_dec_idx, inv_done_idx, rd_idx;
    logic [ST_W-1:0]  wr_state_data, rd_state;
    logic [CNT_W-1:0] inv_ld_cnt, rd_cnt;
    logic [TAG_W-1:0] rd_tag;
    logic [PAY_W-1:0] rd_payload;
    logic             full, empty;
    logic [IDX_W:0]   free_cnt;

    l2_reqs_tracker dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_set(alloc_set), .alloc_state(alloc_state), .alloc_payload(alloc_payload),
        .alloc_idx(alloc_idx),
        .lookup_en(lookup_en), .lookup_tag(lookup_tag), .lookup_set(lookup_set),
        .lookup_hit(lookup_hit), .lookup_idx(lookup_idx), .set_conflict(set_conflict),
        .wr_state_en(wr_state_en), .wr_state_idx(wr_state_idx), .wr_state_data(wr_state_data),
        .free_en(free_en), .free_idx(free_idx),
        .inv_ld_en(inv_ld_en), .inv_ld_idx(inv_ld_idx), .inv_ld_cnt(inv_ld_cnt),
        .inv_dec_en(inv_dec_en), .inv_dec_idx(inv_dec_idx),
        .inv_done(inv_done), .inv_done_idx(inv_done_idx),
        .rd_idx(rd_idx), .rd_state(rd_state), .rd_tag(rd_tag), .rd_payload(rd_payload),
        .rd_cnt(rd_cnt), .full(full), .empty(empty), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic             conf;
    } lk_t;

    int  n_vec = 0;
    int  n_err = 0;
    int  exp_alloc[$];
    int  exp_done[$];
    lk_t exp_lk[$];
    logic lk_pend;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input int tag, input int set, input logic hit, input int idx, input logic conf);
        lk_t e;
        lookup_en  = 1'b1;
        lookup_tag = TAG_W'(tag);
        lookup_set = SET_W'(set);
        e.hit = hit; e.idx = IDX_W'(idx); e.conf = conf;
        exp_lk.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_alloc_ready"},  64'(alloc_ready), 64'd1);
        chk({tag, "_alloc_idx"},    64'(alloc_idx), 64'd0);
        chk({tag, "_lookup_hit"},   64'(lookup_hit), 64'd0);
        chk({tag, "_lookup_idx"},   64'(lookup_idx), 64'd0);
        chk({tag, "_set_conflict"}, 64'(set_conflict), 64'd0);
        chk({tag, "_inv_done"},     64'(inv_done), 64'd0);
        chk({tag, "_inv_done_idx"}, 64'(inv_done_idx), 64'd0);
        chk({tag, "_full"},         64'(full), 64'd0);
        chk({tag, "_empty"},        64'(empty), 64'd1);
        chk({tag, "_free_cnt"},     64'(free_cnt), 64'd4);
    endtask

    always @(posedge clk or posedge rst) lk_pend <= rst ? 1'b0 : lookup_en;

    always @(negedge clk) begin
        if (!rst && alloc_valid && alloc_ready) begin
            if (exp_alloc.size() == 0) chk("alloc_unexpected", 64'd1, 64'd0);
            else chk("alloc_idx", 64'(alloc_idx), 64'(exp_alloc.pop_front()));
        end
        if (lk_pend) begin
            if (exp_lk.size() == 0) chk("lookup_unexpected", 64'd1, 64'd0);
            else begin
                lk_t e;
                e = exp_lk.pop_front();
                chk("lookup_hit", 64'(lookup_hit), 64'(e.hit));
                chk("lookup_idx", 64'(lookup_idx), 64'(e.idx));
                chk("set_conflict", 64'(set_conflict), 64'(e.conf));
            end
        end
        if (inv_done) begin
            if (exp_done.size() == 0) chk("inv_done_unexpected", 64'd1, 64'd0);
            else chk("inv_done_idx", 64'(inv_done_idx), 64'(exp_done.pop_front()));
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        alloc_valid = 0; alloc_tag = '0; alloc_set = '0; alloc_state = '0; alloc_payload = '0;
        lookup_en = 0; lookup_tag = '0; lookup_set = '0;
        wr_state_en = 0; wr_state_idx = '0; wr_state_data = '0; free_en = 0; free_idx = '0;
        inv_ld_en = 0; inv_ld_idx = '0; inv_ld_cnt = '0; inv_dec_en = 0; inv_dec_idx = '0;
        rd_idx = '0;
        #1;
        chk_reset("in_rst");
        #10 rst = 1'b0;
        tick();
        chk_reset("post_rst");

        // Fill the table: set 3, tags 0x10..0x13
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1; alloc_tag = TAG_W'(16 + i); alloc_set = 8'd3;
            alloc_state = 5'd3; alloc_payload = 64'(160 + i);
            exp_alloc.push_back(i);
            tick();
        end
        alloc_valid = 0;
        chk("full_after_fill", 64'(full), 64'd1);
        chk("free_cnt_after_fill", 64'(free_cnt), 64'd0);
        chk("alloc_ready_full", 64'(alloc_ready), 64'd0);
        chk("empty_after_fill", 64'(empty), 64'd0);
        rd_idx = 2'd3; #1;
        chk("rd_tag3", 64'(rd_tag), 64'h13);
        chk("rd_cnt3_ones", 64'(rd_cnt), 64'hF);
        chk("rd_payload3", 64'(rd_payload), 64'hA3);
        chk("rd_state3", 64'(rd_state), 64'd3);

        lookup(16'h12, 3, 1, 2, 1); tick();
        lookup(16'h10, 3, 1, 0, 1); tick();
        lookup(16'h12, 5, 0, 0, 0); tick();
        lookup_en = 0; lookup_tag = 20'h13; lookup_set = 8'd3;
        tick(); tick();
        chk("lookup_hold_hit", 64'(lookup_hit), 64'd0);
        chk("lookup_hold_conf", 64'(set_conflict), 64'd0);

        // Free while full with alloc pending: alloc stalls this cycle, lands on 2 next cycle
        alloc_valid = 1; alloc_tag = 20'h20; alloc_set = 8'd4; alloc_payload = 64'hBEEF;
        free_en = 1; free_idx = 2'd2;
        tick();
        free_en = 0;
        chk("free_cnt_after_free", 64'(free_cnt), 64'd1);
        chk("alloc_ready_after_free", 64'(alloc_ready), 64'd1);
        exp_alloc.push_back(2);
        lookup(16'h20, 4, 0, 0, 0);  // same-cycle alloc not yet visible
        tick();
        alloc_valid = 0;
        chk("full_after_realloc", 64'(full), 64'd1);
        lookup(16'h20, 4, 1, 2, 1); tick();
        lookup(16'h12, 3, 0, 0, 1); tick();
        lookup_en = 0;

        // Invack counting on entry 1
        inv_ld_en = 1; inv_ld_idx = 2'd1; inv_ld_cnt = 4'd2; tick();
        inv_ld_en = 0; inv_dec_en = 1; inv_dec_idx = 2'd1; tick();
        exp_done.push_back(1); tick();
        tick();
        inv_dec_en = 0; tick();
        rd_idx = 2'd1; #1;
        chk("rd_cnt1_sat", 64'(rd_cnt), 64'd0);
        inv_ld_en = 1; inv_ld_idx = 2'd3; inv_ld_cnt = 4'd0;
        exp_done.push_back(3); tick();
        inv_ld_idx = 2'd0; inv_ld_cnt = 4'd5; inv_dec_en = 1; inv_dec_idx = 2'd0; tick();
        inv_ld_en = 0; inv_dec_en = 0;
        rd_idx = 2'd0; #1;
        chk("rd_cnt0_ld_wins", 64'(rd_cnt), 64'd5);

        // State writes and frees
        wr_state_en = 1; wr_state_idx = 2'd0; wr_state_data = 5'd7;
        free_en = 1; free_idx = 2'd0; tick();
        wr_state_en = 0; free_en = 0;
        rd_idx = 2'd0; #1;
        chk("rd_state0_free_wins", 64'(rd_state), 64'd0);
        chk("free_cnt_wr_free", 64'(free_cnt), 64'd1);
        chk("full_wr_free", 64'(full), 64'd0);
        chk("alloc_idx_wr_free", 64'(alloc_idx), 64'd0);
        wr_state_en = 1; wr_state_idx = 2'd1; wr_state_data = 5'd0; tick();
        wr_state_en = 0;
        chk("free_cnt_wr_invalid", 64'(free_cnt), 64'd2);
        free_en = 1; free_idx = 2'd0;
        inv_ld_en = 1; inv_ld_idx = 2'd0; inv_ld_cnt = 4'd0;  // invalid entry: no pulse
        tick();
        free_en = 0; inv_ld_en = 0;
        chk("free_cnt_free_noop", 64'(free_cnt), 64'd2);
        wr_state_en = 1; wr_state_idx = 2'd3; wr_state_data = 5'd9; tick();
        wr_state_en = 0;
        rd_idx = 2'd3; #1;
        chk("rd_state3_wr", 64'(rd_state), 64'd9);
        chk("rd_tag3_kept", 64'(rd_tag), 64'h13);
        alloc_valid = 1; alloc_tag = 20'h30; alloc_set = 8'd6;
        exp_alloc.push_back(0); tick();
        alloc_valid = 0;
        chk("free_cnt_realloc", 64'(free_cnt), 64'd1);

        // Reset mid-stream with a done-producing load in flight
        inv_ld_en = 1; inv_ld_idx = 2'd2; inv_ld_cnt = 4'd0;
        rst = 1'b1;
        rd_idx = 2'd2; #1;
        chk_reset("mid_rst");
        chk("rd_state2_rst", 64'(rd_state), 64'd0);
        chk("rd_tag2_rst", 64'(rd_tag), 64'd0);
        chk("rd_payload2_rst", 64'(rd_payload), 64'd0);
        tick();
        inv_ld_en = 0;
        rst = 1'b0;
        tick();
        chk_reset("after_mid_rst");

        tick();
        chk("alloc_q_left", 64'(exp_alloc.size()), 64'd0);
        chk("lookup_q_left", 64'(exp_lk.size()), 64'd0);
        chk("done_q_left", 64'(exp_done.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/l2_reqs_tracker.md
L2_REQS_TRACKER -- requirements
Module: l2_reqs_tracker

Interface
REQ-001 SHALL have parameter N_ENTRIES, 4, table depth (power of 2, 2..16); IDX_W = clog2(N_ENTRIES).
REQ-002 SHALL have parameter TAG_W, 20, line tag width; SET_W, 8, set index width.
REQ-003 SHALL have parameter ST_W, 5, unstable-state width; state value 0 is INVALID (shared package constant).
REQ-004 SHALL have parameter CNT_W, 4, invack counter width; PAY_W, 64, opaque per-entry payload width (cpu_msg/hsize/hprot/word/amo packed by caller).
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-high reset.
REQ-006 SHALL have ports: alloc_valid in 1, alloc_ready out 1, alloc_tag in TAG_W, alloc_set in SET_W, alloc_state in ST_W (nonzero), alloc_payload in PAY_W, alloc_idx out IDX_W (entry chosen, combinational).
REQ-007 SHALL have ports: lookup_en in 1, lookup_tag in TAG_W, lookup_set in SET_W, lookup_hit out 1, lookup_idx out IDX_W, set_conflict out 1.
REQ-008 SHALL have ports: wr_state_en in 1, wr_state_idx in IDX_W, wr_state_data in ST_W; free_en in 1, free_idx in IDX_W.
REQ-009 SHALL have ports: inv_ld_en in 1, inv_ld_idx in IDX_W, inv_ld_cnt in CNT_W; inv_dec_en in 1, inv_dec_idx in IDX_W; inv_done out 1, inv_done_idx out IDX_W.
REQ-010 SHALL have ports: rd_idx in IDX_W, rd_state out ST_W, rd_tag out TAG_W, rd_payload out PAY_W, rd_cnt out CNT_W (combinational read); full out 1, empty out 1, free_cnt out IDX_W+1.

Function
REQ-011 Entry valid SHALL mean state != INVALID; alloc_ready = !full; alloc_idx = lowest-index invalid entry.
REQ-012 alloc_valid && alloc_ready SHALL, at next edge, write tag/set/state/payload to alloc_idx and load its counter with all-ones (CNT_W).
REQ-013 lookup_en SHALL register, next cycle, lookup_hit (any valid entry with matching tag and set), lookup_idx (highest matching index, 0 if none), set_conflict (any valid entry with matching set); outputs SHALL hold when lookup_en low.
REQ-014 Lookup SHALL evaluate table contents before same-cycle alloc/free/state writes.
REQ-015 wr_state_en SHALL overwrite the state of wr_state_idx; writing INVALID frees the entry.
REQ-016 free_en SHALL set state of free_idx to INVALID; free SHALL win over wr_state_en to the same index; free of an invalid entry is a no-op.
REQ-017 Alloc and free in one cycle SHALL both take effect; free_cnt changes net by 0; alloc SHALL never target the entry being freed (it was valid).
REQ-018 inv_ld_en SHALL load inv_ld_cnt; inv_dec_en SHALL decrement saturating at 0; load SHALL win over decrement to the same index; both ignored on invalid entries.
REQ-019 A decrement taking a counter 1->0, or a load of 0, SHALL pulse inv_done for exactly one cycle, registered, with inv_done_idx; simultaneous done on two entries is illegal (assertion).
REQ-020 full/empty/free_cnt SHALL be registered, reflecting table state after each edge; free_cnt range 0..N_ENTRIES.

Reset
REQ-021 rst high SHALL asynchronously clear all states to INVALID, tags/sets/payload/counters to 0.
REQ-022 During/after reset: alloc_ready=1, alloc_idx=0, lookup_hit=0, lookup_idx=0, set_conflict=0, inv_done=0, inv_done_idx=0, full=0, empty=1, free_cnt=N_ENTRIES.
REQ-023 Reset mid-operation SHALL drop all in-flight entries; no inv_done pulse on the cycle reset deasserts.

Structure
REQ-024 INVALID encoding, reqs_entry_t typedef and N_ENTRIES default SHALL live in the shared spandex package.
REQ-025 A sub-module l2_reqs_prio_enc (parametrised lowest/highest-index priority encoder) SHALL be used for alloc_idx and lookup_idx.

Verification
REQ-026 Reset, then 4 allocs (set 3, tags 0x10..0x13) -> alloc_idx 0,1,2,3; full=1, free_cnt=0, alloc_ready=0.
REQ-027 Full table; free_en idx 2 with alloc_valid same cycle -> free accepted, alloc stalled; next cycle alloc_idx=2 accepted.
REQ-028 lookup tag 0x12 set 3 -> lookup_hit=1, lookup_idx=2 next cycle; lookup set 5 -> hit=0, set_conflict=0.
REQ-029 inv_ld idx1 cnt 2, dec, dec -> inv_done=1 one cycle, inv_done_idx=1; further dec keeps counter 0, no pulse.
REQ-030 wr_state_en and free_en same idx 0 -> entry INVALID, free_cnt +1; assert rst mid-stream -> all REQ-022 values immediately.
